// File: rtl/if_id_buffer.sv
// Two-entry IF/ID pipeline buffer: holds fetched {instruction, pc, next_pc} until
// decode accepts them, handles branch flushes and raises a sticky stop on halt.
module if_id_buffer #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_instruction,
    input  logic [ADDR_WIDTH-1:0] in_pc,
    input  logic [ADDR_WIDTH-1:0] in_next_pc,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instruction,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [ADDR_WIDTH-1:0] out_next_pc,
    output logic                  pc_stop,
    output logic [1:0]            occupancy
);

    logic [DATA_WIDTH-1:0] instr_q [2];
    logic [ADDR_WIDTH-1:0] pc_q    [2];
    logic [ADDR_WIDTH-1:0] npc_q   [2];

    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       enq;
    logic       deq;
    logic       is_halt;

    // Ready comes from registered state only, so a full buffer never enqueues
    // in the same cycle it dequeues; the freed slot is offered next cycle.
    assign in_ready  = (count != 2'd2) && !pc_stop;
    assign out_valid = (count != 2'd0);
    assign occupancy = count;
    assign enq       = in_valid && in_ready && !flush;
    assign deq       = out_valid && out_ready && !flush;
    assign is_halt   = (in_instruction[DATA_WIDTH-1 -: 4] == HALT_OPCODE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
            pc_stop <= 1'b0;
        end else if (flush) begin
            // The halt (if any) was on the wrong path, so the stop is dropped too.
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
            pc_stop <= 1'b0;
        end else begin
            if (enq) begin
                wr_ptr <= ~wr_ptr;
            end
            if (deq) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({enq, deq})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (enq && is_halt) begin
                pc_stop <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (enq) begin
            instr_q[wr_ptr] <= in_instruction;
            pc_q[wr_ptr]    <= in_pc;
            npc_q[wr_ptr]   <= in_next_pc;
        end
    end

    always_comb begin
        out_instruction = '0;
        out_pc          = '0;
        out_next_pc     = '0;
        if (out_valid) begin
            out_instruction = instr_q[rd_ptr];
            out_pc          = pc_q[rd_ptr];
            out_next_pc     = npc_q[rd_ptr];
        end
    end

endmodule

// File: tb/tb_if_id_buffer.sv
// Scoreboard bench for if_id_buffer: driver pushes accepted fetches into a queue,
// a negedge monitor compares the DUT against the queue-based reference.
module tb_if_id_buffer;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] npc;
    } entry_t;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instruction;
    logic [15:0] in_pc;
    logic [15:0] in_next_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instruction;
    logic [15:0] out_pc;
    logic [15:0] out_next_pc;
    logic        pc_stop;
    logic [1:0]  occupancy;

    entry_t sb[$];
    logic   halt;
    logic   exp_ready;
    logic   accepted;
    int     pass_cnt;
    int     total_cnt;

    if_id_buffer #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (16),
        .HALT_OPCODE(4'hF)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_instruction (in_instruction),
        .in_pc          (in_pc),
        .in_next_pc     (in_next_pc),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instruction(out_instruction),
        .out_pc         (out_pc),
        .out_next_pc    (out_next_pc),
        .pc_stop        (pc_stop),
        .occupancy      (occupancy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    // Monitor: compare DUT state with the reference queue, then retire the head.
    always @(negedge clock) begin
        if (reset) begin
            sb.delete();
            halt = 1'b0;
        end
        exp_ready = (sb.size() != 2) && !halt;
        check("in_ready",  {31'd0, in_ready},  {31'd0, exp_ready});
        check("out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
        check("occupancy", {30'd0, occupancy}, sb.size());
        check("pc_stop",   {31'd0, pc_stop},   {31'd0, halt});
        if (sb.size() != 0) begin
            check("out_instruction", {16'd0, out_instruction}, {16'd0, sb[0].instr});
            check("out_pc",          {16'd0, out_pc},          {16'd0, sb[0].pc});
            check("out_next_pc",     {16'd0, out_next_pc},     {16'd0, sb[0].npc});
        end else begin
            check("empty_fields", {out_instruction, out_pc | out_next_pc}, 32'd0);
        end
        if (!reset) begin
            if (flush) begin
                sb.delete();
                halt = 1'b0;
            end else if (sb.size() != 0 && out_ready) begin
                void'(sb.pop_front());
            end
        end
    end

    // One cycle of stimulus; the accepted fetch is pushed after the monitor has run.
    task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                         input logic fl, input logic ordy);
        entry_t e;
        @(posedge clock);
        #1;
        in_valid       = v;
        in_instruction = ins;
        in_pc          = pc;
        in_next_pc     = pc + 16'd2;
        flush          = fl;
        out_ready      = ordy;
        @(negedge clock);
        #1;
        accepted = !reset && !fl && v && exp_ready;
        if (accepted) begin
            e.instr = ins;
            e.pc    = pc;
            e.npc   = pc + 16'd2;
            sb.push_back(e);
            if (ins[15:12] == 4'hF) halt = 1'b1;
        end
    endtask

    // Fetch holds the instruction until it is taken, with a bounded wait.
    task automatic offer(input logic [15:0] ins, input logic [15:0] pc, input logic ordy);
        int unsigned tries;
        tries = 0;
        do begin
            drive(1'b1, ins, pc, 1'b0, ordy);
            tries++;
        end while (!accepted && tries < 20);
        check("offer_accepted", {31'd0, accepted}, 32'd1);
    endtask

    task automatic idle(input int unsigned n, input logic ordy);
        for (int unsigned i = 0; i < n; i++) drive(1'b0, 16'h0000, 16'h0000, 1'b0, ordy);
    endtask

    initial begin
        pass_cnt       = 0;
        total_cnt      = 0;
        halt           = 1'b0;
        exp_ready      = 1'b1;
        accepted       = 1'b0;
        reset          = 1'b1;
        in_valid       = 1'b0;
        in_instruction = '0;
        in_pc          = '0;
        in_next_pc     = '0;
        flush          = 1'b0;
        out_ready      = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // streaming with decode always ready
        drive(1'b1, 16'h1234, 16'h0000, 1'b0, 1'b1);
        drive(1'b1, 16'h5678, 16'h0002, 1'b0, 1'b1);
        drive(1'b1, 16'h9ABC, 16'h0004, 1'b0, 1'b1);
        idle(2, 1'b1);

        // decode stall: two stored, third held until a slot frees
        offer(16'h1111, 16'h0020, 1'b0);
        offer(16'h2222, 16'h0022, 1'b0);
        drive(1'b1, 16'h3333, 16'h0024, 1'b0, 1'b0);
        drive(1'b1, 16'h3333, 16'h0024, 1'b0, 1'b0);
        check("stall_held", {31'd0, accepted}, 32'd0);
        offer(16'h3333, 16'h0024, 1'b1);
        idle(3, 1'b1);

        // flush while full with a fetch offered
        offer(16'h4444, 16'h0030, 1'b0);
        offer(16'h5555, 16'h0032, 1'b0);
        drive(1'b1, 16'h6666, 16'h0034, 1'b1, 1'b0);
        idle(2, 1'b0);

        // halt: sticky stop, delivered normally, cleared by flush
        offer(16'hF000, 16'h0010, 1'b0);
        idle(2, 1'b0);
        idle(3, 1'b1);
        drive(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1);
        idle(1, 1'b1);

        // asynchronous reset with two entries and a pending halt
        offer(16'h7777, 16'h0040, 1'b0);
        offer(16'hF123, 16'h0042, 1'b0);
        idle(1, 1'b0);
        @(posedge clock);
        #1 in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("async_out_valid", {31'd0, out_valid}, 32'd0);
        check("async_occupancy", {30'd0, occupancy}, 32'd0);
        check("async_pc_stop",   {31'd0, pc_stop},   32'd0);
        check("async_in_ready",  {31'd0, in_ready},  32'd1);
        check("async_out_instr", {16'd0, out_instruction}, 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        drive(1'b1, 16'h0ABC, 16'h0100, 1'b0, 1'b1);
        idle(1, 1'b1);

        // simultaneous enqueue/dequeue across pointer wraps
        for (int unsigned i = 0; i < 8; i++) begin
            drive(1'b1, 16'h0100 + 16'(i), 16'h0200 + 16'(2 * i), 1'b0, 1'b1);
        end
        idle(2, 1'b1);

        // randomized traffic
        for (int unsigned i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) < 7, 16'($urandom), 16'($urandom) & 16'hFFFE,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 6);
        end
        idle(3, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule
